// File: rtl/pio_loader_pkg.sv
// Shared constants and encodings for the pio loader: action codes, pio geometry
// and the state enums used by the sequencer.
package pio_loader_pkg;

  localparam int PIO_NUM_SM     = 4;
  localparam int PIO_PROG_DEPTH = 32;
  localparam int PIO_IDX_W      = $clog2(PIO_PROG_DEPTH);
  localparam int PIO_MIDX_W     = $clog2(PIO_NUM_SM);
  localparam int PIO_ACT_W      = 6;

  localparam logic [PIO_ACT_W-1:0] ACT_NONE  = 6'd0;
  localparam logic [PIO_ACT_W-1:0] ACT_INSTR = 6'd1;
  localparam logic [PIO_ACT_W-1:0] ACT_PUSH  = 6'd4;

  typedef enum logic [1:0] {
    ST_LOAD_PROG = 2'd0,
    ST_LOAD_CONF = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  // Where the visible action/din come from this cycle.
  typedef enum logic [1:0] {
    SRC_REG  = 2'd0,
    SRC_PROG = 2'd1,
    SRC_CONF = 2'd2
  } src_t;

  typedef enum logic [1:0] {
    TAIL_ISSUE = 2'd0,
    TAIL_LAST  = 2'd1,
    TAIL_IDLE  = 2'd2
  } tail_t;

  function automatic logic [PIO_ACT_W-1:0] conf_action(input logic [35:0] word);
    return {2'b00, word[35:32]};
  endfunction

endpackage

// File: rtl/pio_loader_if.sv
// pio control bus plus the TX push handshake; master is the loader side,
// slave is the pio/push-source side.
interface pio_loader_if;
  import pio_loader_pkg::*;

  logic                  push_valid;
  logic [31:0]           push_data;
  logic [PIO_MIDX_W-1:0] push_mindex;
  logic                  push_ready;
  logic [PIO_NUM_SM-1:0] tx_full;
  logic [PIO_ACT_W-1:0]  action;
  logic [31:0]           din;
  logic [PIO_IDX_W-1:0]  index;
  logic [PIO_MIDX_W-1:0] mindex;
  logic                  loaded;

  modport master (
    input  push_valid, push_data, push_mindex, tx_full,
    output push_ready, action, din, index, mindex, loaded
  );

  modport slave (
    output push_valid, push_data, push_mindex, tx_full,
    input  push_ready, action, din, index, mindex, loaded
  );

endinterface

// File: rtl/pio_loader.sv
// Sequencer upstream of pio: streams program ROM, then per-machine config ROM,
// into pio after reset or reload, then forwards TX pushes gated by tx_full.
module pio_loader
  import pio_loader_pkg::*;
#(
  parameter int PROG_LEN     = 32,
  parameter int NUM_MACHINES = 2,
  parameter int CONF_LEN     = 10,
  parameter int CONF_AW      = 7
) (
  input  logic                 clk,
  input  logic                 n_reset,
  output logic [PIO_IDX_W-1:0] o_prog_addr,
  input  logic [15:0]          i_prog_data,
  output logic [CONF_AW-1:0]   o_conf_addr,
  input  logic [35:0]          i_conf_data,
  input  logic                 i_reload,
  pio_loader_if.master         bus
);

  state_t                r_state, w_state;
  src_t                  r_src, w_src;
  tail_t                 r_tail, w_tail;
  logic [5:0]            r_pcnt, w_pcnt;
  logic [CONF_AW-1:0]    r_caddr, w_caddr;
  logic [4:0]            r_e, w_e;
  logic [PIO_MIDX_W-1:0] r_m, w_m;
  logic [PIO_ACT_W-1:0]  r_action, w_action;
  logic [31:0]           r_din, w_din;
  logic [PIO_IDX_W-1:0]  r_index, w_index;
  logic [PIO_MIDX_W-1:0] r_mindex, w_mindex;
  logic                  r_pushed, w_pushed;
  logic [PIO_MIDX_W-1:0] r_last_m, w_last_m;

  logic                  w_prog_busy;
  logic                  w_conf_last;
  logic                  w_push_ready;
  logic                  w_accept;
  logic [PIO_ACT_W-1:0]  w_out_action;
  logic [31:0]           w_out_din;

  assign w_prog_busy = (r_pcnt < 6'(PROG_LEN));
  assign w_conf_last = (r_e == 5'(CONF_LEN - 1)) && (r_m == PIO_MIDX_W'(NUM_MACHINES - 1));
  assign w_accept    = bus.push_valid && w_push_ready;

  // ROM data arrives one cycle after its address, so load-phase writes pass the
  // ROM word straight through instead of adding a second cycle of latency.
  always_comb begin
    w_out_action = r_action;
    w_out_din    = r_din;
    case (r_src)
      SRC_PROG: begin
        w_out_action = ACT_INSTR;
        w_out_din    = {16'h0000, i_prog_data};
      end
      SRC_CONF: begin
        w_out_action = conf_action(i_conf_data);
        w_out_din    = i_conf_data[31:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state      = r_state;
    w_src        = SRC_REG;
    w_tail       = r_tail;
    w_pcnt       = r_pcnt;
    w_caddr      = r_caddr;
    w_e          = r_e;
    w_m          = r_m;
    w_action     = ACT_NONE;
    w_din        = w_out_din;
    w_index      = r_index;
    w_mindex     = r_mindex;
    w_pushed     = 1'b0;
    w_last_m     = r_last_m;
    w_push_ready = 1'b0;

    case (r_state)
      ST_LOAD_PROG: begin
        if (w_prog_busy) begin
          w_src   = SRC_PROG;
          w_index = r_pcnt[PIO_IDX_W-1:0];
          w_pcnt  = r_pcnt + 6'd1;
        end else begin
          w_state = ST_LOAD_CONF;
          w_tail  = TAIL_ISSUE;
          w_caddr = '0;
          w_e     = '0;
          w_m     = '0;
        end
      end

      ST_LOAD_CONF: begin
        case (r_tail)
          TAIL_ISSUE: begin
            w_src    = SRC_CONF;
            w_mindex = r_m;
            if (w_conf_last) begin
              w_tail = TAIL_LAST;
            end else begin
              w_caddr = r_caddr + CONF_AW'(1);
              if (r_e == 5'(CONF_LEN - 1)) begin
                w_e = '0;
                w_m = r_m + PIO_MIDX_W'(1);
              end else begin
                w_e = r_e + 5'd1;
              end
            end
          end
          TAIL_LAST: begin
            w_tail   = TAIL_IDLE;
            w_mindex = '0;
          end
          default: begin
            w_state = ST_RUN;
          end
        endcase
      end

      ST_RUN: begin
        // A push is held off for one cycle after hitting the same machine
        // because tx_full only reflects that push a cycle later.
        if (i_reload) begin
          w_state = ST_LOAD_PROG;
          w_pcnt  = '0;
        end else begin
          w_push_ready = !bus.tx_full[bus.push_mindex] &&
                         !(r_pushed && (r_last_m == bus.push_mindex));
          if (w_accept) begin
            w_action = ACT_PUSH;
            w_din    = bus.push_data;
            w_mindex = bus.push_mindex;
            w_pushed = 1'b1;
            w_last_m = bus.push_mindex;
          end
        end
      end

      default: begin
        w_state = ST_LOAD_PROG;
        w_pcnt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state  <= ST_LOAD_PROG;
      r_src    <= SRC_REG;
      r_tail   <= TAIL_ISSUE;
      r_pcnt   <= '0;
      r_caddr  <= '0;
      r_e      <= '0;
      r_m      <= '0;
      r_action <= ACT_NONE;
      r_din    <= '0;
      r_index  <= '0;
      r_mindex <= '0;
      r_pushed <= 1'b0;
      r_last_m <= '0;
    end else begin
      r_state  <= w_state;
      r_src    <= w_src;
      r_tail   <= w_tail;
      r_pcnt   <= w_pcnt;
      r_caddr  <= w_caddr;
      r_e      <= w_e;
      r_m      <= w_m;
      r_action <= w_action;
      r_din    <= w_din;
      r_index  <= w_index;
      r_mindex <= w_mindex;
      r_pushed <= w_pushed;
      r_last_m <= w_last_m;
    end
  end

  assign o_prog_addr     = w_prog_busy ? r_pcnt[PIO_IDX_W-1:0] : PIO_IDX_W'(PROG_LEN - 1);
  assign o_conf_addr     = r_caddr;
  assign bus.action      = w_out_action;
  assign bus.din         = w_out_din;
  assign bus.index       = r_index;
  assign bus.mindex      = r_mindex;
  assign bus.loaded      = (r_state == ST_RUN);
  assign bus.push_ready  = w_push_ready;

endmodule
